// File: rtl/layer_ram_arbiter_if.sv
// Bundle of the pipeline, controller, config and downstream SDRAM signals seen by layer_ram_arbiter.
// slave is the arbiter's view; master is the view of whatever surrounds it (requesters plus memory).
interface layer_ram_arbiter_if #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int LAYER_W = 3
);
  // Render pipeline (read-only requester)
  logic               pipe_req;
  logic [LAYER_W-1:0] pipe_layer_id;
  logic [ADDR_W-1:0]  pipe_offset;
  logic               pipe_gnt;
  logic               pipe_rvalid;
  logic [DATA_W-1:0]  pipe_rdata;

  // MCU controller (read/write requester)
  logic               ctrl_req;
  logic               ctrl_we;
  logic [LAYER_W-1:0] ctrl_layer_id;
  logic [ADDR_W-1:0]  ctrl_offset;
  logic [DATA_W-1:0]  ctrl_wdata;
  logic               ctrl_gnt;
  logic               ctrl_rvalid;
  logic [DATA_W-1:0]  ctrl_rdata;

  // Base-address table write port
  logic               cfg_we;
  logic [LAYER_W-1:0] cfg_layer_id;
  logic [ADDR_W-1:0]  cfg_base;

  // Downstream SDRAM port
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic               mem_busy;
  logic               mem_rvalid;
  logic [DATA_W-1:0]  mem_rdata;

  logic               err_timeout;

  modport slave (
    input  pipe_req, pipe_layer_id, pipe_offset,
    output pipe_gnt, pipe_rvalid, pipe_rdata,
    input  ctrl_req, ctrl_we, ctrl_layer_id, ctrl_offset, ctrl_wdata,
    output ctrl_gnt, ctrl_rvalid, ctrl_rdata,
    input  cfg_we, cfg_layer_id, cfg_base,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_busy, mem_rvalid, mem_rdata,
    output err_timeout
  );

  modport master (
    output pipe_req, pipe_layer_id, pipe_offset,
    input  pipe_gnt, pipe_rvalid, pipe_rdata,
    output ctrl_req, ctrl_we, ctrl_layer_id, ctrl_offset, ctrl_wdata,
    input  ctrl_gnt, ctrl_rvalid, ctrl_rdata,
    output cfg_we, cfg_layer_id, cfg_base,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_busy, mem_rvalid, mem_rdata,
    input  err_timeout
  );
endinterface

// File: rtl/layer_ram_arbiter.sv
// Shares one layer-RAM SDRAM port between the render pipeline and the MCU controller,
// forming word addresses from a per-layer base table and steering read data back to its owner.
module layer_ram_arbiter #(
  parameter int ADDR_W          = 24,
  parameter int DATA_W          = 16,
  parameter int LAYER_W         = 3,
  parameter int CTRL_STARVE_MAX = 8,
  parameter int RD_TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  layer_ram_arbiter_if.slave    bus
);

  localparam int LAYERS   = 1 << LAYER_W;
  localparam int STREAK_W = $clog2(CTRL_STARVE_MAX + 1);
  localparam int TIMER_W  = $clog2(RD_TIMEOUT + 1);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(CTRL_STARVE_MAX);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD
  } state_t;

  typedef enum logic {
    OWN_PIPE,
    OWN_CTRL
  } owner_t;

  state_t              r_state;
  owner_t              r_owner;
  logic [ADDR_W-1:0]   r_base [LAYERS];
  logic [STREAK_W-1:0] r_streak;
  logic [TIMER_W-1:0]  r_timer;

  logic                r_pipe_gnt;
  logic                r_pipe_rvalid;
  logic [DATA_W-1:0]   r_pipe_rdata;
  logic                r_ctrl_gnt;
  logic                r_ctrl_rvalid;
  logic [DATA_W-1:0]   r_ctrl_rdata;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_err_timeout;

  logic                w_idle;
  logic                w_ctrl_forced;
  logic                w_pipe_win;
  logic                w_ctrl_win;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_pipe_addr;
  logic [ADDR_W-1:0]   w_ctrl_addr;

  // Pipeline wins unless the controller has been starved for CTRL_STARVE_MAX grants.
  assign w_idle        = (r_state == S_IDLE);
  assign w_ctrl_forced = bus.ctrl_req && (r_streak == STREAK_MAX);
  assign w_pipe_win    = bus.pipe_req && !w_ctrl_forced;
  assign w_ctrl_win    = bus.ctrl_req && !w_pipe_win;
  assign w_accept      = r_mem_req && !bus.mem_busy;

  // Sum truncates to ADDR_W, giving the modulo-2**ADDR_W wrap for free.
  assign w_pipe_addr = r_base[bus.pipe_layer_id] + bus.pipe_offset;
  assign w_ctrl_addr = r_base[bus.ctrl_layer_id] + bus.ctrl_offset;

  // NOTE: the base table is only 2**LAYER_W words and must read 0 after reset, so it is
  // built from resettable flops rather than a RAM macro (which could not be cleared in one cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAYERS; i++) begin
        r_base[i] <= '0;
      end
    end else if (bus.cfg_we) begin
      r_base[bus.cfg_layer_id] <= bus.cfg_base;
    end
  end

  // NOTE: every register here uses <= so that all reads in this block see the pre-edge
  // values; a blocking = would let later statements observe half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_owner       <= OWN_PIPE;
      r_streak      <= '0;
      r_timer       <= '0;
      r_pipe_gnt    <= 1'b0;
      r_pipe_rvalid <= 1'b0;
      r_pipe_rdata  <= '0;
      r_ctrl_gnt    <= 1'b0;
      r_ctrl_rvalid <= 1'b0;
      r_ctrl_rdata  <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_pipe_gnt    <= 1'b0;
      r_ctrl_gnt    <= 1'b0;
      r_pipe_rvalid <= 1'b0;
      r_ctrl_rvalid <= 1'b0;

      if (!bus.ctrl_req) begin
        r_streak <= '0;
      end else if (w_idle && w_ctrl_win) begin
        r_streak <= '0;
      end else if (w_idle && w_pipe_win && (r_streak != STREAK_MAX)) begin
        r_streak <= r_streak + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pipe_win) begin
            r_pipe_gnt  <= 1'b1;
            r_owner     <= OWN_PIPE;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= w_pipe_addr;
            r_mem_wdata <= '0;
            r_state     <= S_ISSUE;
          end else if (w_ctrl_win) begin
            r_ctrl_gnt  <= 1'b1;
            r_owner     <= OWN_CTRL;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.ctrl_we;
            r_mem_addr  <= w_ctrl_addr;
            r_mem_wdata <= bus.ctrl_wdata;
            r_state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (w_accept) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_timer   <= '0;
            r_state   <= r_mem_we ? S_IDLE : S_WAIT_RD;
          end
        end

        S_WAIT_RD: begin
          // A real response on the final timer cycle still wins over the timeout.
          if (bus.mem_rvalid || (r_timer == TIMER_LAST)) begin
            if (r_owner == OWN_PIPE) begin
              r_pipe_rvalid <= 1'b1;
              r_pipe_rdata  <= bus.mem_rvalid ? bus.mem_rdata : '0;
            end else begin
              r_ctrl_rvalid <= 1'b1;
              r_ctrl_rdata  <= bus.mem_rvalid ? bus.mem_rdata : '0;
            end
            if (!bus.mem_rvalid) begin
              r_err_timeout <= 1'b1;
            end
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pipe_gnt    = r_pipe_gnt;
  assign bus.pipe_rvalid = r_pipe_rvalid;
  assign bus.pipe_rdata  = r_pipe_rdata;
  assign bus.ctrl_gnt    = r_ctrl_gnt;
  assign bus.ctrl_rvalid = r_ctrl_rvalid;
  assign bus.ctrl_rdata  = r_ctrl_rdata;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.err_timeout = r_err_timeout;

endmodule

// File: tb/tb_layer_ram_arbiter.sv
// Directed bench for layer_ram_arbiter: a tiny memory responder plus hand-computed expectations.
module tb_layer_ram_arbiter;

  localparam int SIG_PIPE_GNT    = 0;
  localparam int SIG_CTRL_GNT    = 1;
  localparam int SIG_PIPE_RVALID = 2;
  localparam int SIG_CTRL_RVALID = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  layer_ram_arbiter_if bus ();

  layer_ram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory responder: answers each accepted read one cycle later when auto_resp is set.
  logic        auto_resp   = 1'b0;
  logic [15:0] resp_data   = 16'h0;
  logic        accept_rd   = 1'b0;
  logic        resp_q      = 1'b0;
  logic        force_rvalid = 1'b0;
  logic [15:0] force_data  = 16'h0;

  always @(posedge clk) accept_rd <= bus.mem_req && !bus.mem_busy && !bus.mem_we && auto_resp;
  always @(negedge clk) resp_q <= accept_rd;

  assign bus.mem_rvalid = resp_q | force_rvalid;
  assign bus.mem_rdata  = force_rvalid ? force_data : (resp_q ? resp_data : 16'h0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_sig(input int which, input int max_cyc, output int cycles);
    logic hit;
    cycles = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      case (which)
        SIG_PIPE_GNT:    hit = bus.pipe_gnt;
        SIG_CTRL_GNT:    hit = bus.ctrl_gnt;
        SIG_PIPE_RVALID: hit = bus.pipe_rvalid;
        default:         hit = bus.ctrl_rvalid;
      endcase
      if (hit) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic cfg_write(input logic [2:0] layer, input logic [23:0] base);
    bus.cfg_we       = 1'b1;
    bus.cfg_layer_id = layer;
    bus.cfg_base     = base;
    tick();
    bus.cfg_we       = 1'b0;
  endtask

  task automatic pipe_read(input logic [2:0] layer, input logic [23:0] off,
                           input logic [23:0] exp_addr, input string tag);
    int cyc;
    bus.pipe_req      = 1'b1;
    bus.pipe_layer_id = layer;
    bus.pipe_offset   = off;
    wait_sig(SIG_PIPE_GNT, 1, cyc);
    check({tag, "_gnt_lat"}, cyc, 1);
    check({tag, "_addr"}, bus.mem_addr, {8'h0, exp_addr});
    bus.pipe_req = 1'b0;
  endtask

  initial begin
    int cyc;
    int seq[10];
    int n_gnt;
    int first_ctrl;
    int n_ctrl;
    logic any_rv;

    bus.pipe_req = 0; bus.pipe_layer_id = 0; bus.pipe_offset = 0;
    bus.ctrl_req = 0; bus.ctrl_we = 0; bus.ctrl_layer_id = 0; bus.ctrl_offset = 0; bus.ctrl_wdata = 0;
    bus.cfg_we = 0; bus.cfg_layer_id = 0; bus.cfg_base = 0;
    bus.mem_busy = 0;

    tick(); tick();
    rst = 1'b0;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_pipe_gnt", bus.pipe_gnt, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_err", bus.err_timeout, 0);

    // 1: basic pipe read
    auto_resp = 1'b1; resp_data = 16'hBEEF;
    cfg_write(3'd2, 24'h001000);
    bus.pipe_req = 1; bus.pipe_layer_id = 3'd2; bus.pipe_offset = 24'h10;
    tick();
    check("t1_gnt", bus.pipe_gnt, 1);
    check("t1_mem_req", bus.mem_req, 1);
    check("t1_addr", bus.mem_addr, 32'h001010);
    check("t1_we", bus.mem_we, 0);
    bus.pipe_req = 0;
    wait_sig(SIG_PIPE_RVALID, 10, cyc);
    check("t1_rv_lat", cyc, 2);
    check("t1_rdata", bus.pipe_rdata, 16'hBEEF);
    check("t1_ctrl_rv", bus.ctrl_rvalid, 0);
    tick();
    check("t1_rv_pulse", bus.pipe_rvalid, 0);
    check("t1_rdata_hold", bus.pipe_rdata, 16'hBEEF);

    // 2: ctrl write with address wrap, held under busy
    cfg_write(3'd7, 24'hFFFFF0);
    bus.mem_busy = 1;
    bus.ctrl_req = 1; bus.ctrl_we = 1; bus.ctrl_layer_id = 3'd7;
    bus.ctrl_offset = 24'h20; bus.ctrl_wdata = 16'h1234;
    tick();
    check("t2_gnt", bus.ctrl_gnt, 1);
    check("t2_addr", bus.mem_addr, 32'h000010);
    check("t2_we", bus.mem_we, 1);
    check("t2_wdata", bus.mem_wdata, 16'h1234);
    bus.ctrl_req = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_hold_req", bus.mem_req, 1);
      check("t2_hold_addr", bus.mem_addr, 32'h000010);
    end
    bus.mem_busy = 0;
    tick();
    check("t2_req_drop", bus.mem_req, 0);
    any_rv = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      any_rv = any_rv | bus.pipe_rvalid | bus.ctrl_rvalid;
    end
    check("t2_no_rvalid", any_rv, 0);

    // 3: starvation, pipe and ctrl both held
    resp_data = 16'h1111;
    for (int i = 0; i < 10; i++) seq[i] = 2;
    n_gnt = 0;
    bus.pipe_req = 1; bus.pipe_layer_id = 3'd0; bus.pipe_offset = 24'h0;
    bus.ctrl_req = 1; bus.ctrl_we = 1; bus.ctrl_layer_id = 3'd0; bus.ctrl_offset = 24'h8;
    for (int c = 0; c < 300 && n_gnt < 10; c++) begin
      tick();
      if (bus.pipe_gnt) begin
        seq[n_gnt] = 0;
        n_gnt++;
      end
      if (bus.ctrl_gnt && n_gnt < 10) begin
        seq[n_gnt] = 1;
        n_gnt++;
        check("t3_streak_clr", dut.r_streak, 0);
        bus.ctrl_req = 0;
      end
    end
    bus.pipe_req = 0;
    bus.ctrl_req = 0;
    check("t3_n_gnt", n_gnt, 10);
    first_ctrl = -1;
    n_ctrl = 0;
    for (int i = 0; i < 10; i++) begin
      if (seq[i] == 1) begin
        n_ctrl++;
        if (first_ctrl < 0) first_ctrl = i;
      end
    end
    check("t3_pipe_run", first_ctrl, 8);
    check("t3_n_ctrl", n_ctrl, 1);
    check("t3_resume", seq[9], 0);
    repeat (6) tick();

    // 4: ctrl read normal, then timeout, then recovery
    resp_data = 16'hCAFE;
    bus.ctrl_req = 1; bus.ctrl_we = 0; bus.ctrl_layer_id = 3'd0; bus.ctrl_offset = 24'h5;
    wait_sig(SIG_CTRL_GNT, 2, cyc);
    check("t4_gnt_lat", cyc, 1);
    bus.ctrl_req = 0;
    wait_sig(SIG_CTRL_RVALID, 10, cyc);
    check("t4_rv_lat", cyc, 2);
    check("t4_rdata", bus.ctrl_rdata, 16'hCAFE);
    tick();
    auto_resp = 0;
    bus.ctrl_req = 1;
    wait_sig(SIG_CTRL_GNT, 2, cyc);
    check("t4b_gnt_lat", cyc, 1);
    bus.ctrl_req = 0;
    wait_sig(SIG_CTRL_RVALID, 300, cyc);
    check("t4b_timeout_lat", cyc, 256);
    check("t4b_rdata0", bus.ctrl_rdata, 0);
    check("t4b_err", bus.err_timeout, 1);
    check("t4b_pipe_rv", bus.pipe_rvalid, 0);
    tick();
    check("t4b_rv_pulse", bus.ctrl_rvalid, 0);
    check("t4b_err_sticky", bus.err_timeout, 1);
    auto_resp = 1; resp_data = 16'h5A5A;
    pipe_read(3'd2, 24'h3, 24'h001003, "t4c");
    wait_sig(SIG_PIPE_RVALID, 10, cyc);
    check("t4c_rv_lat", cyc, 2);
    check("t4c_rdata", bus.pipe_rdata, 16'h5A5A);
    check("t4c_err", bus.err_timeout, 1);
    tick();

    // 5: reset while waiting for read data
    auto_resp = 0;
    cfg_write(3'd3, 24'h002000);
    pipe_read(3'd3, 24'h1, 24'h002001, "t5");
    tick(); tick();
    check("t5_in_wait_req", bus.mem_req, 0);
    rst = 1;
    tick();
    rst = 0;
    check("t5_rst_addr", bus.mem_addr, 0);
    check("t5_rst_rdata", bus.pipe_rdata, 0);
    check("t5_rst_err", bus.err_timeout, 0);
    check("t5_rst_gnt", bus.pipe_gnt, 0);
    force_rvalid = 1; force_data = 16'h7777;
    tick();
    force_rvalid = 0;
    any_rv = bus.pipe_rvalid | bus.ctrl_rvalid;
    for (int i = 0; i < 2; i++) begin
      tick();
      any_rv = any_rv | bus.pipe_rvalid | bus.ctrl_rvalid;
    end
    check("t5_late_rv_ignored", any_rv, 0);
    auto_resp = 1; resp_data = 16'h0101;
    pipe_read(3'd3, 24'h1, 24'h000001, "t5_base_clr");
    wait_sig(SIG_PIPE_RVALID, 10, cyc);
    check("t5_drain", cyc, 2);

    // 6: cfg write in the same cycle as a grant on that layer
    cfg_write(3'd1, 24'h000100);
    bus.pipe_req = 1; bus.pipe_layer_id = 3'd1; bus.pipe_offset = 24'h4;
    bus.cfg_we = 1; bus.cfg_layer_id = 3'd1; bus.cfg_base = 24'h000400;
    tick();
    bus.cfg_we = 0;
    bus.pipe_req = 0;
    check("t6_gnt", bus.pipe_gnt, 1);
    check("t6_old_base", bus.mem_addr, 32'h000104);
    wait_sig(SIG_PIPE_RVALID, 10, cyc);
    check("t6_drain", cyc, 2);
    pipe_read(3'd1, 24'h4, 24'h000404, "t6_new_base");
    wait_sig(SIG_PIPE_RVALID, 10, cyc);
    check("t6b_drain", cyc, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
